// File: rtl/gray_frame_writer_if.sv
// Camera-in / SRAM-out bundle of gray_frame_writer.
// slave: the writer itself; master: whatever drives the camera side.
interface gray_frame_writer_if;
   logic        start;
   logic        sof;
   logic        valid;
   logic [9:0]  r;
   logic [9:0]  g;
   logic [9:0]  b;
   logic [19:0] sram_addr;
   logic [15:0] sram_dq;
   logic        sram_we_n;
   logic        sram_ce_n;
   logic        sram_oe_n;
   logic        sram_lb_n;
   logic        sram_ub_n;
   logic        busy;
   logic        done;
   logic        overflow;

   modport slave (
      input  start, sof, valid, r, g, b,
      output sram_addr, sram_dq, sram_we_n,
      output sram_ce_n, sram_oe_n, sram_lb_n, sram_ub_n,
      output busy, done, overflow
   );

   modport master (
      output start, sof, valid, r, g, b,
      input  sram_addr, sram_dq, sram_we_n,
      input  sram_ce_n, sram_oe_n, sram_lb_n, sram_ub_n,
      input  busy, done, overflow
   );
endinterface

// File: rtl/gray_frame_writer.sv
// Captures one RGB frame, converts to 10-bit luma, writes it to SRAM.
// Ports: clk, rst (sync, active-high), bus (gray_frame_writer_if.slave).
module gray_frame_writer #(
   parameter int          WIDTH      = 640,
   parameter int          HEIGHT     = 480,
   parameter int          PIXELS     = 307200,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [19:0] BASE_ADDR  = 20'd0
) (
   input  logic               clk,
   input  logic               rst,
   gray_frame_writer_if.slave bus
);
   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam logic [18:0] LAST_PIX = 19'(PIXELS - 1);
   localparam bit          SINGLE   = (PIXELS == 1);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
   begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two >= 2");
   end

   if (PIXELS < 1 || PIXELS > (1 << 19) || PIXELS > WIDTH * HEIGHT)
   begin : g_bad_pixels
      $error("PIXELS out of range for the frame geometry");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_CAPTURE,
      S_DRAIN
   } state_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_STROBE,
      W_HOLD
   } wstate_t;

   typedef struct packed {
      logic [19:0] addr;
      logic [9:0]  gray;
   } entry_t;

   state_t      state, state_n;
   wstate_t     wstate, wstate_n;
   logic [18:0] pix, pix_n;
   logic        accept;
   logic        clr_ovf;
   logic        done_n;
   logic        done;
   logic        overflow;

   logic [17:0] luma;
   logic [9:0]  gray;
   logic [19:0] pix_addr;

   entry_t      mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   entry_t      head;
   logic        empty, full;
   logic        push, pop, drop;

   logic [19:0] wr_addr;
   logic [15:0] wr_data;
   logic        we_n;

   // Weights sum to 256, so the 18-bit sum never exceeds 256*1023.
   always_comb begin
      luma = 18'd77  * 18'(bus.r)
           + 18'd150 * 18'(bus.g)
           + 18'd29  * 18'(bus.b);
      gray = 10'(luma >> 8);
   end

   assign pix_addr = BASE_ADDR + {1'b0, pix};

   // Extra pointer bit separates full from empty.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW])
               && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   // The engine can take a new word whenever it is not mid-strobe,
   // so HOLD doubles as IDLE for back-to-back writes.
   assign pop  = !empty && (wstate != W_STROBE);
   assign push = accept && (!full || pop);
   assign drop = accept && full && !pop;

   always_comb begin
      state_n = state;
      pix_n   = pix;
      accept  = 1'b0;
      clr_ovf = 1'b0;
      done_n  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus.start) begin
               state_n = S_ARMED;
               pix_n   = '0;
               clr_ovf = 1'b1;
            end
         end
         S_ARMED: begin
            if (bus.valid && bus.sof) begin
               accept  = 1'b1;
               pix_n   = 19'd1;
               state_n = SINGLE ? S_DRAIN : S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (bus.valid) begin
               accept = 1'b1;
               pix_n  = pix + 19'd1;
               if (pix == LAST_PIX) begin
                  state_n = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (empty && wstate == W_IDLE) begin
               state_n = S_IDLE;
               done_n  = 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         pix      <= '0;
         done     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state <= state_n;
         pix   <= pix_n;
         done  <= done_n;
         if (clr_ovf) begin
            overflow <= 1'b0;
         end else if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= '{addr: pix_addr, gray: gray};
      end
   end

   always_comb begin
      wstate_n = wstate;
      unique case (wstate)
         W_IDLE: begin
            if (!empty) begin
               wstate_n = W_STROBE;
            end
         end
         W_STROBE: wstate_n = W_HOLD;
         W_HOLD: begin
            wstate_n = empty ? W_IDLE : W_STROBE;
         end
         default: wstate_n = W_IDLE;
      endcase
   end

   // Address and data load with the pop, so they are stable
   // for the whole low strobe and the following hold cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wstate  <= W_IDLE;
         wr_addr <= BASE_ADDR;
         wr_data <= '0;
         we_n    <= 1'b1;
      end else begin
         wstate <= wstate_n;
         we_n   <= (wstate_n != W_STROBE);
         if (pop) begin
            wr_addr <= head.addr;
            wr_data <= {6'd0, head.gray};
         end
      end
   end

   assign bus.sram_addr = wr_addr;
   assign bus.sram_dq   = wr_data;
   assign bus.sram_we_n = we_n;
   assign bus.sram_ce_n = 1'b0;
   assign bus.sram_oe_n = 1'b1;
   assign bus.sram_lb_n = 1'b0;
   assign bus.sram_ub_n = 1'b0;
   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = done;
   assign bus.overflow  = overflow;
endmodule

// File: tb/tb_gray_frame_writer.sv
// Self-checking bench for gray_frame_writer (32-pixel frame).
// Scoreboard of expected SRAM writes, checked by a negedge monitor.
module tb_gray_frame_writer;
   localparam int          PIXELS = 32;
   localparam logic [19:0] BASE   = 20'h00040;

   typedef struct packed {
      logic [19:0] addr;
      logic [9:0]  gray;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gray_frame_writer_if bus ();

   gray_frame_writer #(
      .WIDTH      (8),
      .HEIGHT     (4),
      .PIXELS     (PIXELS),
      .FIFO_DEPTH (4),
      .BASE_ADDR  (BASE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          errors = 0;
   int          checks = 0;
   exp_t        sb [$];
   logic [15:0] sram [logic [19:0]];
   int          cyc = 0;
   int          writes = 0;
   int          drops = 0;
   int          done_cnt = 0;
   int          last_write_cyc = -100;
   int          first_write_cyc = -1;
   logic [19:0] last_addr = '0;
   bit          allow_drop = 1'b0;
   bit          prev_we_low = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [9:0] luma(input int r, input int g, input int b);
      int s;
      s = 77 * r + 150 * g + 29 * b;
      return 10'(s >> 8);
   endfunction

   always @(negedge clk) begin : mon
      exp_t e;
      if (bus.sram_we_n === 1'b0) begin
         checks++;
         if (prev_we_low) begin
            errors++;
            $display("FAIL we_n_double: we_n low 2 cycles, addr=%h",
                     bus.sram_addr);
         end
         while (allow_drop && sb.size() > 0 &&
                sb[0].addr != bus.sram_addr) begin
            drops++;
            void'(sb.pop_front());
         end
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr=%h dq=%h, none expected",
                     bus.sram_addr, bus.sram_dq);
         end else begin
            e = sb.pop_front();
            if (bus.sram_addr !== e.addr ||
                bus.sram_dq !== {6'd0, e.gray}) begin
               errors++;
               $display("FAIL write: got addr=%h dq=%h, want addr=%h dq=%h",
                        bus.sram_addr, bus.sram_dq, e.addr, {6'd0, e.gray});
            end
         end
         sram[bus.sram_addr] = bus.sram_dq;
         writes++;
         last_addr = bus.sram_addr;
         if (first_write_cyc < 0) first_write_cyc = cyc;
         last_write_cyc = cyc;
      end
      if (bus.done === 1'b1) begin
         done_cnt++;
         checks++;
         if (bus.busy !== 1'b0 || cyc - last_write_cyc < 2 ||
             sb.size() != 0) begin
            errors++;
            $display("FAIL done_early: busy=%b since_write=%0d pending=%0d, want 0/>=2/0",
                     bus.busy, cyc - last_write_cyc, sb.size());
         end
      end
      prev_we_low = (bus.sram_we_n === 1'b0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      writes = 0;
      drops = 0;
      done_cnt = 0;
      first_write_cyc = -1;
      sram.delete();
   endtask

   task automatic start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic pixel(input int r, input int g, input int b,
                        input bit sof, input bit acc, input int idx);
      exp_t e;
      bus.valid = 1'b1;
      bus.sof   = sof;
      bus.r     = 10'(r);
      bus.g     = 10'(g);
      bus.b     = 10'(b);
      if (acc) begin
         e.addr = 20'(BASE + idx);
         e.gray = luma(r, g, b);
         sb.push_back(e);
      end
      tick();
      bus.valid = 1'b0;
      bus.sof   = 1'b0;
   endtask

   task automatic run_pixels(input int first, input int last, input int gap);
      for (int i = first; i <= last; i++) begin
         pixel($urandom_range(0, 1023), $urandom_range(0, 1023),
               $urandom_range(0, 1023), i == 0, 1'b1, i);
         repeat (gap) tick();
      end
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done_cnt == 0 && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (done_cnt == 0) begin
         errors++;
         $display("FAIL done_timeout: no done within %0d cycles", budget);
      end
   endtask

   task automatic count_written(input int first, input int last,
                                output int n);
      n = 0;
      for (int i = first; i <= last; i++) begin
         if (sram.exists(20'(BASE + i))) n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      checks++;
      if (bus.sram_we_n !== 1'b1) begin
         errors++;
         $display("FAIL rst_we_n: got %b want 1", bus.sram_we_n);
      end
      checks++;
      if (bus.sram_addr !== BASE || bus.sram_dq !== 16'd0) begin
         errors++;
         $display("FAIL rst_bus: got addr=%h dq=%h want %h/0",
                  bus.sram_addr, bus.sram_dq, BASE);
      end
      checks++;
      if ({bus.busy, bus.done, bus.overflow} !== 3'b000) begin
         errors++;
         $display("FAIL rst_status: got busy/done/ovf=%b want 000",
                  {bus.busy, bus.done, bus.overflow});
      end
      checks++;
      if ({bus.sram_ce_n, bus.sram_oe_n, bus.sram_lb_n, bus.sram_ub_n}
          !== 4'b0100) begin
         errors++;
         $display("FAIL rst_ctrl: got ce/oe/lb/ub=%b want 0100",
                  {bus.sram_ce_n, bus.sram_oe_n,
                   bus.sram_lb_n, bus.sram_ub_n});
      end
   endtask

   task automatic test_white();
      int acc_cyc;
      clear_stats();
      start();
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL white_busy: got %b want 1", bus.busy);
      end
      acc_cyc = 0;
      for (int i = 0; i < PIXELS; i++) begin
         pixel(1023, 1023, 1023, i == 0, 1'b1, i);
         if (i == 0) acc_cyc = cyc;
         tick();
      end
      wait_done(200);
      checks++;
      if (first_write_cyc !== acc_cyc + 1) begin
         errors++;
         $display("FAIL white_latency: got cycle %0d want %0d",
                  first_write_cyc, acc_cyc + 1);
      end
      checks++;
      if (writes !== PIXELS || last_addr !== 20'(BASE + PIXELS - 1)) begin
         errors++;
         $display("FAIL white_count: got %0d writes last=%h want %0d/%h",
                  writes, last_addr, PIXELS, 20'(BASE + PIXELS - 1));
      end
      checks++;
      if (sram[20'(BASE + 5)] !== 16'h03FF) begin
         errors++;
         $display("FAIL white_dq: got %h want 03ff", sram[20'(BASE + 5)]);
      end
      repeat (4) tick();
      checks++;
      if (done_cnt !== 1 || bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL white_end: got done=%0d busy=%b ovf=%b want 1/0/0",
                  done_cnt, bus.busy, bus.overflow);
      end
   endtask

   task automatic test_luma();
      clear_stats();
      start();
      pixel(1000, 0, 0, 1'b1, 1'b1, 0);
      tick();
      pixel(0, 1000, 0, 1'b0, 1'b1, 1);
      tick();
      pixel(0, 0, 1000, 1'b0, 1'b1, 2);
      tick();
      run_pixels(3, PIXELS - 1, 1);
      wait_done(200);
      checks++;
      if (sram[20'(BASE)] !== 16'd300) begin
         errors++;
         $display("FAIL luma_red: got %0d want 300", sram[20'(BASE)]);
      end
      checks++;
      if (sram[20'(BASE + 1)] !== 16'd585) begin
         errors++;
         $display("FAIL luma_green: got %0d want 585", sram[20'(BASE + 1)]);
      end
      checks++;
      if (sram[20'(BASE + 2)] !== 16'd113) begin
         errors++;
         $display("FAIL luma_blue: got %0d want 113", sram[20'(BASE + 2)]);
      end
      repeat (4) tick();
   endtask

   task automatic test_overflow();
      int n;
      clear_stats();
      start();
      run_pixels(0, 4, 0);
      repeat (12) tick();
      checks++;
      if (writes !== 5 || bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL burst5: got writes=%0d ovf=%b want 5/0",
                  writes, bus.overflow);
      end
      allow_drop = 1'b1;
      run_pixels(5, 16, 0);
      checks++;
      if (bus.overflow !== 1'b1) begin
         errors++;
         $display("FAIL burst12_ovf: got %b want 1", bus.overflow);
      end
      repeat (14) tick();
      allow_drop = 1'b0;
      while (sb.size() > 0) begin
         drops++;
         void'(sb.pop_front());
      end
      checks++;
      if (drops < 1 || writes + drops !== 17) begin
         errors++;
         $display("FAIL burst12_drops: got drops=%0d writes=%0d want >=1, sum 17",
                  drops, writes);
      end
      count_written(5, 16, n);
      checks++;
      if (n !== 12 - drops) begin
         errors++;
         $display("FAIL burst12_holes: got %0d written want %0d",
                  n, 12 - drops);
      end
      run_pixels(17, PIXELS - 1, 1);
      wait_done(200);
      count_written(17, PIXELS - 1, n);
      checks++;
      if (n !== PIXELS - 17) begin
         errors++;
         $display("FAIL after_drop_index: got %0d written want %0d",
                  n, PIXELS - 17);
      end
      repeat (4) tick();
      checks++;
      if (bus.overflow !== 1'b1 || done_cnt !== 1) begin
         errors++;
         $display("FAIL ovf_sticky: got ovf=%b done=%0d want 1/1",
                  bus.overflow, done_cnt);
      end
   endtask

   task automatic test_ignore();
      clear_stats();
      start();
      checks++;
      if (bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: got %b want 0", bus.overflow);
      end
      for (int i = 0; i < 3; i++) begin
         pixel(500, 500, 500, 1'b0, 1'b0, 0);
         tick();
      end
      repeat (4) tick();
      checks++;
      if (writes !== 0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL armed_nosof: got writes=%0d busy=%b want 0/1",
                  writes, bus.busy);
      end
      for (int i = 0; i < PIXELS; i++) begin
         pixel($urandom_range(0, 1023), $urandom_range(0, 1023),
               $urandom_range(0, 1023), (i == 0) || (i == 10), 1'b1, i);
         if (i == 6) start();
         else tick();
      end
      wait_done(200);
      repeat (4) tick();
      checks++;
      if (writes !== PIXELS || done_cnt !== 1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL ignore_end: got writes=%0d done=%0d busy=%b want %0d/1/0",
                  writes, done_cnt, bus.busy, PIXELS);
      end
   endtask

   task automatic test_reset_mid();
      clear_stats();
      start();
      run_pixels(0, 9, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (bus.sram_we_n !== 1'b1 || bus.sram_addr !== BASE ||
          bus.sram_dq !== 16'd0) begin
         errors++;
         $display("FAIL midrst_bus: got we_n=%b addr=%h dq=%h want 1/%h/0",
                  bus.sram_we_n, bus.sram_addr, bus.sram_dq, BASE);
      end
      checks++;
      if ({bus.busy, bus.done, bus.overflow} !== 3'b000) begin
         errors++;
         $display("FAIL midrst_status: got %b want 000",
                  {bus.busy, bus.done, bus.overflow});
      end
      sb.delete();
      writes = 0;
      done_cnt = 0;
      repeat (10) tick();
      checks++;
      if (writes !== 0 || done_cnt !== 0) begin
         errors++;
         $display("FAIL midrst_quiet: got writes=%0d done=%0d want 0/0",
                  writes, done_cnt);
      end
   endtask

   task automatic test_back_to_back();
      clear_stats();
      start();
      run_pixels(0, PIXELS - 1, 1);
      wait_done(200);
      repeat (4) tick();
      checks++;
      if (writes !== PIXELS || last_addr !== 20'(BASE + PIXELS - 1)) begin
         errors++;
         $display("FAIL frame_count: got %0d last=%h want %0d/%h",
                  writes, last_addr, PIXELS, 20'(BASE + PIXELS - 1));
      end
      checks++;
      if (done_cnt !== 1 || bus.overflow !== 1'b0 || sb.size() != 0) begin
         errors++;
         $display("FAIL frame_end: got done=%0d ovf=%b pend=%0d want 1/0/0",
                  done_cnt, bus.overflow, sb.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 1'b0;
      bus.sof   = 1'b0;
      bus.valid = 1'b0;
      bus.r     = '0;
      bus.g     = '0;
      bus.b     = '0;
      test_reset();
      test_white();
      test_luma();
      test_overflow();
      test_ignore();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
